// File: rtl/moore_seq_pkg.sv
// Shared types and constants for the programmable Moore sequence detector.
package moore_seq_pkg;

  // Pattern length limits accepted at elaboration
  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 8;

  // FSM encoding; 2'b11 is unused and recovers to S_FILL
  typedef enum logic [1:0] {
    S_FILL  = 2'b00,
    S_ARMED = 2'b01,
    S_HIT   = 2'b10
  } state_e;

endpackage

// File: rtl/moore_seq_prefix.sv
// Combinational prefix matcher: for the candidate history/valid count of this
// cycle, finds the longest pattern prefix that ends at the newest sample.
module moore_seq_prefix
  import moore_seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int PW    = $clog2(PAT_W + 1)
) (
  input  logic [PAT_W-1:0] hist_i,
  input  logic [PW-1:0]    vcnt_i,
  input  logic [PAT_W-1:0] pat_i,
  output logic [PW-1:0]    prog_o,
  output logic             match_o
);

  // hit[k]: the newest k samples are valid and equal the first k pattern bits
  logic [PAT_W:1] hit;

  for (genvar k = 1; k <= PAT_W; k++) begin : g_pfx
    assign hit[k] = (vcnt_i >= PW'(k)) && (hist_i[k-1:0] == pat_i[PAT_W-1 -: k]);
  end

  // Longest matching prefix wins; later iterations overwrite shorter ones
  always_comb begin
    prog_o = '0;
    for (int k = 1; k <= PAT_W; k++) begin
      if (hit[k]) prog_o = PW'(k);
    end
  end

  // A full-length prefix is a complete match
  assign match_o = hit[PAT_W];

endmodule

// File: rtl/moore_seq_detector.sv
// Runtime-programmable Moore sequence detector with overlap control.
// Optional build macro: MOORE_SEQ_MATCH_CNT_EN adds a saturating match counter;
// without it match_cnt is tied to zero.
module moore_seq_detector
  import moore_seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
  parameter int               CNT_W   = 8,
  localparam int              PW      = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             pattern_ld,
  input  logic [PAT_W-1:0] pattern_in,
  output logic [1:0]       state,
  output logic             z,
  output logic [PW-1:0]    prog,
  output logic [CNT_W-1:0] match_cnt
);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("moore_seq_detector: PAT_W must be in 2..8");
  end

  localparam logic [PW-1:0] VFULL = PW'(PAT_W);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PW-1:0]    vcnt_q, vcnt_d;
  logic [PW-1:0]    prog_q, prog_d;

  // Candidate values if this cycle's x is consumed
  logic [PAT_W-1:0] hist_s;
  logic [PW-1:0]    vcnt_s;
  logic [PW-1:0]    prog_s;
  logic             match_s;

  assign hist_s = {hist_q[PAT_W-2:0], x};
  assign vcnt_s = (vcnt_q == VFULL) ? vcnt_q : vcnt_q + PW'(1);

  moore_seq_prefix #(.PAT_W(PAT_W), .PW(PW)) u_prefix (
    .hist_i  (hist_s),
    .vcnt_i  (vcnt_s),
    .pat_i   (pat_q),
    .prog_o  (prog_s),
    .match_o (match_s)
  );

  // Next-state: pattern load beats sampling; a non-overlap hit restarts the
  // window (vcnt and prog to 0) while still entering S_HIT.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    vcnt_d  = vcnt_q;
    prog_d  = prog_q;
    if (pattern_ld) begin
      pat_d   = pattern_in;
      hist_d  = '0;
      vcnt_d  = '0;
      prog_d  = '0;
      state_d = S_FILL;
    end else if (en) begin
      hist_d = hist_s;
      vcnt_d = vcnt_s;
      prog_d = prog_s;
      if (match_s) begin
        state_d = S_HIT;
        if (!overlap) begin
          vcnt_d = '0;
          prog_d = '0;
        end
      end else if (vcnt_s == VFULL) begin
        state_d = S_ARMED;
      end else begin
        state_d = S_FILL;
      end
    end else begin
      case (state_q)
        S_HIT:   state_d = (vcnt_q == VFULL) ? S_ARMED : S_FILL;
        S_FILL:  state_d = S_FILL;
        S_ARMED: state_d = S_ARMED;
        default: state_d = S_FILL;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      pat_q   <= PAT_RST;
      hist_q  <= '0;
      vcnt_q  <= '0;
      prog_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      vcnt_q  <= vcnt_d;
      prog_q  <= prog_d;
    end
  end

  assign state = state_q;
  assign z     = (state_q == S_HIT);
  assign prog  = prog_q;

`ifdef MOORE_SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_take;

  // Every accepted match is one entry into S_HIT
  assign hit_take = !pattern_ld && en && match_s;

  // Saturating increment on each match
  always_comb begin
    cnt_d = cnt_q;
    if (hit_take && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Match counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Self-checking bench: vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_moore_seq_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, x, overlap, pattern_ld;
  logic [3:0] pattern_in;
  logic [1:0] state, state2;
  logic       z, z2;
  logic [2:0] prog, prog2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  moore_seq_detector #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
    .pattern_ld(pattern_ld), .pattern_in(pattern_in),
    .state(state), .z(z), .prog(prog), .match_cnt(match_cnt)
  );

  moore_seq_detector #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
    .pattern_ld(pattern_ld), .pattern_in(pattern_in),
    .state(state2), .z(z2), .prog(prog2), .match_cnt(match_cnt2)
  );

  // Reference model: the bits seen since the last restart, oldest first
  bit       mq[$];
  bit [3:0] mpat;
  int       mstate, mprog, mcnt, mcnt2;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    mpat = 4'b1011; mstate = 0; mprog = 0; mcnt = 0; mcnt2 = 0;
  endtask

  // Longest k with the newest k bits equal to the first k pattern bits
  function automatic int m_prefix();
    int best = 0;
    for (int k = 1; k <= mq.size(); k++) begin
      bit ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (mq[mq.size() - k + j] != mpat[3 - j]) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  task automatic m_step(input bit e, input bit xx, input bit ov, input bit ld,
                        input bit [3:0] pin);
    if (ld) begin
      mpat = pin; mq.delete(); mprog = 0; mstate = 0;
    end else if (e) begin
      mq.push_back(xx);
      if (mq.size() > 4) void'(mq.pop_front());
      mprog = m_prefix();
      if (mprog == 4) begin
        mstate = 2;
        if (mcnt < 255) mcnt++;
        if (mcnt2 < 3) mcnt2++;
        if (!ov) begin
          mq.delete(); mprog = 0;
        end
      end else begin
        mstate = (mq.size() == 4) ? 1 : 0;
      end
    end else if (mstate == 2) begin
      mstate = (mq.size() == 4) ? 1 : 0;
    end
  endtask

  task automatic check_model();
    chk("m_state", state, mstate);
    chk("m_z", z, (mstate == 2) ? 1 : 0);
    chk("m_prog", prog, mprog);
    chk("m_z2", z2, (mstate == 2) ? 1 : 0);
`ifdef MOORE_SEQ_MATCH_CNT_EN
    chk("m_cnt", match_cnt, mcnt);
    chk("m_cnt2", match_cnt2, mcnt2);
`else
    chk("m_cnt", match_cnt, 0);
    chk("m_cnt2", match_cnt2, 0);
`endif
  endtask

  // One clock: drive inputs, step model at the edge, check just after it
  task automatic cyc(input bit e, input bit xx, input bit ov, input bit ld,
                     input bit [3:0] pin);
    en = e; x = xx; overlap = ov; pattern_ld = ld; pattern_in = pin;
    @(posedge clk);
    m_step(e, xx, ov, ld, pin);
    #1;
    check_model();
    en = 1'b0; pattern_ld = 1'b0;
  endtask

  // Asynchronous reset between edges, released just after an edge
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk({tag, "_state"}, state, 0);
    chk({tag, "_z"}, z, 0);
    chk({tag, "_prog"}, prog, 0);
    chk({tag, "_cnt"}, match_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic feed(input bit ov, input bit [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i], ov, 1'b0, 4'h0);
  endtask

  typedef struct {
    bit       en, x, ov, ld;
    bit [3:0] pin;
    bit       ez;
    int       eprog;
    int       estate;
  } vec_t;

  vec_t tbl[15];

  initial begin
    rst = 1'b1; en = 0; x = 0; overlap = 0; pattern_ld = 0; pattern_in = 0;
    m_reset();
    tbl = '{
      // pattern 1011, overlap: stream 1011011
      '{1,1,1,0,4'h0, 0,1,0}, '{1,0,1,0,4'h0, 0,2,0}, '{1,1,1,0,4'h0, 0,3,0},
      '{1,1,1,0,4'h0, 1,4,2}, '{1,0,1,0,4'h0, 0,2,1}, '{1,1,1,0,4'h0, 0,3,1},
      '{1,1,1,0,4'h0, 1,4,2},
      // idle cycle leaves S_HIT, prog holds
      '{0,0,1,0,4'h0, 0,4,1},
      // load 0110 with a sample in the same cycle: sample is dropped
      '{1,1,1,1,4'h6, 0,0,0},
      '{1,0,1,0,4'h0, 0,1,0}, '{1,1,1,0,4'h0, 0,2,0}, '{1,1,1,0,4'h0, 0,3,0},
      '{1,0,1,0,4'h0, 1,4,2},
      // idle, then an idle cycle on S_ARMED holds
      '{0,0,1,0,4'h0, 0,4,1}, '{0,1,1,0,4'h0, 0,4,1}
    };
    @(posedge clk); #1;
    chk("rst_state", state, 0);
    chk("rst_z", z, 0);
    chk("rst_prog", prog, 0);
    chk("rst_cnt", match_cnt, 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].en, tbl[i].x, tbl[i].ov, tbl[i].ld, tbl[i].pin);
      chk($sformatf("tbl%0d_z", i), z, tbl[i].ez);
      chk($sformatf("tbl%0d_prog", i), prog, tbl[i].eprog);
      chk($sformatf("tbl%0d_state", i), state, tbl[i].estate);
    end

    // Reset with 3 of 4 bits of 0110 matched; pattern must return to 1011
    feed(1'b1, 16'b011, 3);
    do_reset("rstmid");
    feed(1'b1, 16'b101, 3);
    chk("rstmid_nohit", z, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    chk("rstmid_pat1011", z, 1);

    // Non-overlap: 10111011 hits after bits 4 and 8 only
    do_reset("novl");
    begin
      bit [7:0] s  = 8'b10111011;
      bit [7:0] ez = 8'b00010001;
      for (int i = 7; i >= 0; i--) begin
        cyc(1'b1, s[i], 1'b0, 1'b0, 4'h0);
        chk($sformatf("novl_z%0d", 8 - i), z, ez[i]);
        if (i == 4) chk("novl_prog_after_hit", prog, 0);
      end
    end

    // 1111 overlapping: six ones keep z high three cycles, then saturate dut2
    do_reset("ones");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
    begin
      bit [5:0] ez = 6'b000111;
      for (int i = 5; i >= 0; i--) begin
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        chk($sformatf("ones_z%0d", 6 - i), z, ez[i]);
      end
    end
    feed(1'b1, 16'b11, 2);
`ifdef MOORE_SEQ_MATCH_CNT_EN
    chk("sat_cnt8", match_cnt, 5);
    chk("sat_cnt2", match_cnt2, 3);
`else
    chk("nocnt_cnt8", match_cnt, 0);
    chk("nocnt_cnt2", match_cnt2, 0);
`endif

    // Randomized run against the model
    begin
      bit ov = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        int r = $urandom_range(0, 199);
        if (r < 2) begin
          do_reset("rnd_rst");
        end else if (r < 8) begin
          cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ov, 1'b1,
              4'($urandom_range(0, 15)));
        end else begin
          if (r < 14) ov = ~ov;
          cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, ov, 1'b0, 4'h0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
